// File: rtl/sddr_pkg.sv
// Shared types and constants for the DDR3 PHY read-capture path.
package sddr_pkg;

  localparam int BURST_LEN     = 8;
  localparam int BEATS_PER_CLK = 2;
  localparam int CAP_CYCLES    = BURST_LEN / BEATS_PER_CLK;

  // Each state names the last capture cycle whose beats are already stored.
  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    B3
  } burst_state_t;

  function automatic int rd_word_width(input int data_bits);
    return BURST_LEN * data_bits;
  endfunction

endpackage

// File: rtl/sddr_rd_fifo.sv
// Synchronous FIFO with full/empty flags; reads as zero while empty.
module sddr_rd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sddr_rd_capture.sv
// DDR3 PHY read-return path: latency tracking, BL8 capture, output buffering.
// Build option: define SDDR_RD_DQS_CHECK_EN to enable the per-lane DQS pattern check.
module sddr_rd_capture
  import sddr_pkg::*;
#(
  parameter  int DATA_BITS      = 16,
  parameter  int MAX_RD_LATENCY = 32,
  parameter  int FIFO_DEPTH     = 4,
  localparam int LANES          = DATA_BITS / 8,
  localparam int LAT_W          = $clog2(MAX_RD_LATENCY + 1),
  localparam int WORD_W         = rd_word_width(DATA_BITS)
) (
  input  logic              in_ddr_clock_i,
  input  logic              in_phy_reset_n_i,
  input  logic              rd_cmd_i,
  input  logic [LAT_W-1:0]  cfg_rd_latency_i,
  input  logic [DATA_BITS-1:0] dq_rise_i,
  input  logic [DATA_BITS-1:0] dq_fall_i,
  input  logic [LANES-1:0]  dqs_rise_i,
  input  logic [LANES-1:0]  dqs_fall_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  input  logic              err_clear_i,
  output logic              overflow_o,
  output logic              spacing_err_o,
  output logic              dqs_err_o
);

  localparam int TAP_W  = $clog2(MAX_RD_LATENCY);
  localparam int PAIR_W = BEATS_PER_CLK * DATA_BITS;
  localparam int HOLD_W = (CAP_CYCLES - 1) * PAIR_W;

  burst_state_t              state_q, state_d;
  logic [MAX_RD_LATENCY-1:0] pend_q;
  logic [LAT_W-1:0]          lat_q;
  logic [LAT_W-1:0]          lat_clamped;
  logic [TAP_W-1:0]          tap_idx;
  logic                      tap;
  logic                      idle;
  logic                      capture;
  logic                      push;
  logic                      pop;
  logic [1:0]                cool_q;
  logic [HOLD_W-1:0]         hold_q;
  logic [PAIR_W-1:0]         pair;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      overflow_q;
  logic                      spacing_q;

  assign idle    = (state_q == IDLE) && (pend_q == '0);
  assign tap_idx = TAP_W'(lat_q - LAT_W'(1));
  assign tap     = pend_q[tap_idx];
  assign pair    = {dq_fall_i, dq_rise_i};

  always_comb begin
    lat_clamped = cfg_rd_latency_i;
    if (cfg_rd_latency_i == '0)
      lat_clamped = LAT_W'(1);
    else if (cfg_rd_latency_i > LAT_W'(MAX_RD_LATENCY))
      lat_clamped = LAT_W'(MAX_RD_LATENCY);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (tap) begin capture = 1'b1; state_d = B0; end
      B0:   begin capture = 1'b1; state_d = B1; end
      B1:   begin capture = 1'b1; state_d = B2; end
      B2:   begin capture = 1'b1; push = 1'b1; state_d = B3; end
      // A tap here is the seamless back-to-back burst starting in this very cycle.
      B3:   if (tap) begin capture = 1'b1; state_d = B0; end
                 else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_ddr_clock_i or negedge in_phy_reset_n_i) begin
    if (!in_phy_reset_n_i) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      lat_q      <= LAT_W'(1);
      cool_q     <= '0;
      overflow_q <= 1'b0;
      spacing_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= {pend_q[MAX_RD_LATENCY-2:0], rd_cmd_i};
      if (idle) lat_q <= lat_clamped;
      if (rd_cmd_i)            cool_q <= 2'd3;
      else if (cool_q != '0)   cool_q <= cool_q - 2'd1;
      spacing_q  <= (rd_cmd_i && (cool_q != '0)) | (spacing_q & ~err_clear_i);
      overflow_q <= (push & fifo_full & ~pop) | (overflow_q & ~err_clear_i);
    end
  end

  // Earlier capture pairs slide down so beat 0 ends up in the LSBs of the word.
  always_ff @(posedge in_ddr_clock_i) begin
    if (capture) hold_q <= {pair, hold_q[HOLD_W-1:PAIR_W]};
  end

`ifdef SDDR_RD_DQS_CHECK_EN
  logic dqs_q;
  logic dqs_bad;

  assign dqs_bad = (dqs_rise_i != '1) || (dqs_fall_i != '0);

  always_ff @(posedge in_ddr_clock_i or negedge in_phy_reset_n_i) begin
    if (!in_phy_reset_n_i) dqs_q <= 1'b0;
    else                   dqs_q <= (capture & dqs_bad) | (dqs_q & ~err_clear_i);
  end

  assign dqs_err_o = dqs_q;
`else
  logic unused_dqs;
  assign unused_dqs = ^{dqs_rise_i, dqs_fall_i};
  assign dqs_err_o  = 1'b0;
`endif

  assign rd_valid_o    = ~fifo_empty;
  assign pop           = rd_valid_o & rd_ready_i;
  assign overflow_o    = overflow_q;
  assign spacing_err_o = spacing_q;

  sddr_rd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (in_ddr_clock_i),
    .rst_n (in_phy_reset_n_i),
    .push  (push),
    .pop   (pop),
    .wdata ({pair, hold_q}),
    .rdata (rd_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sddr_rd_capture.sv
// Scoreboard bench for sddr_rd_capture: directed reads, monitor compares popped words.
module tb_sddr_rd_capture;

  localparam int LAT = 5;
`ifdef SDDR_RD_DQS_CHECK_EN
  localparam bit DQS_EXP = 1'b1;
`else
  localparam bit DQS_EXP = 1'b0;
`endif

  typedef struct {
    logic [127:0] word;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_cmd_i;
  logic [5:0]   cfg_rd_latency_i;
  logic [15:0]  dq_rise_i, dq_fall_i;
  logic [1:0]   dqs_rise_i, dqs_fall_i;
  logic [127:0] rd_data_o;
  logic         rd_valid_o, rd_ready_i, err_clear_i;
  logic         overflow_o, spacing_err_o, dqs_err_o;

  exp_t        sb[$];
  logic [15:0] rise_tab[int];
  logic [15:0] fall_tab[int];
  logic [1:0]  dqs_fall_tab[int];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  sddr_rd_capture dut (
    .in_ddr_clock_i   (clk),
    .in_phy_reset_n_i (rst_n),
    .rd_cmd_i         (rd_cmd_i),
    .cfg_rd_latency_i (cfg_rd_latency_i),
    .dq_rise_i        (dq_rise_i),
    .dq_fall_i        (dq_fall_i),
    .dqs_rise_i       (dqs_rise_i),
    .dqs_fall_i       (dqs_fall_i),
    .rd_data_o        (rd_data_o),
    .rd_valid_o       (rd_valid_o),
    .rd_ready_i       (rd_ready_i),
    .err_clear_i      (err_clear_i),
    .overflow_o       (overflow_o),
    .spacing_err_o    (spacing_err_o),
    .dqs_err_o        (dqs_err_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {127'b0, act}, {127'b0, exp});
  endtask

  function automatic logic [15:0] beat(input logic [7:0] tag, input int j);
    return {tag, 8'(j + 1)};
  endfunction

  function automatic logic [127:0] burst_word(input logic [7:0] tag);
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[16*j +: 16] = beat(tag, j);
    return w;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) next_cycle();
  endtask

  task automatic sample_at(input int n);
    wait_cycle(n);
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) next_cycle();
  endtask

  // READ issued in the current cycle: schedule its beats and, if tracked, its expected word.
  task automatic read_cmd(input logic [7:0] tag, input int lat, input bit track, input bit timed);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      rise_tab[cyc + lat + k] = beat(tag, 2*k);
      fall_tab[cyc + lat + k] = beat(tag, 2*k + 1);
    end
    e.word = burst_word(tag);
    e.due  = timed ? cyc + lat + 4 : -1;
    if (track) sb.push_back(e);
    rd_cmd_i = 1'b1;
    next_cycle();
    rd_cmd_i = 1'b0;
  endtask

  task automatic pulse_clear();
    next_cycle();
    err_clear_i = 1'b1;
    next_cycle();
    err_clear_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      next_cycle();
      n++;
    end
    next_cycle();
    check(name, 128'(sb.size()), 128'(0));
  endtask

  // Input driver for the PHY side: beats and DQS levels per cycle.
  initial begin
    dq_rise_i  = '0;
    dq_fall_i  = '0;
    dqs_rise_i = 2'b11;
    dqs_fall_i = 2'b00;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      dq_rise_i  = rise_tab.exists(cyc) ? rise_tab[cyc] : 16'h0;
      dq_fall_i  = fall_tab.exists(cyc) ? fall_tab[cyc] : 16'h0;
      dqs_fall_i = dqs_fall_tab.exists(cyc) ? dqs_fall_tab[cyc] : 2'b00;
    end
  end

  // Monitor: every accepted word is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid_o && rd_ready_i) begin
        if (sb.size() == 0) begin
          chk1("unexpected_word", rd_valid_o, 1'b0);
        end else begin
          e = sb.pop_front();
          check("word", rd_data_o, e.word);
          if (e.due >= 0) check("pop_cycle", 128'(cyc), 128'(e.due));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n            = 1'b0;
    rd_cmd_i         = 1'b0;
    cfg_rd_latency_i = 6'(LAT);
    rd_ready_i       = 1'b0;
    err_clear_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_valid", rd_valid_o, 1'b0);
    check("reset_data", rd_data_o, '0);
    chk1("reset_overflow", overflow_o, 1'b0);
    chk1("reset_spacing", spacing_err_o, 1'b0);
    chk1("reset_dqs", dqs_err_o, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    gap(4);

    // 1: single read, exact latency, pop clears valid; latency change in flight ignored
    rd_ready_i = 1'b1;
    c = cyc;
    read_cmd(8'h00, LAT, 1'b1, 1'b1);
    cfg_rd_latency_i = 6'd9;
    sample_at(c + LAT + 3);
    chk1("t1_valid_early", rd_valid_o, 1'b0);
    sample_at(c + LAT + 4);
    chk1("t1_valid_due", rd_valid_o, 1'b1);
    sample_at(c + LAT + 5);
    chk1("t1_valid_popped", rd_valid_o, 1'b0);
    cfg_rd_latency_i = 6'(LAT);
    gap(40);

    // 2: seamless back-to-back reads four cycles apart
    c = cyc;
    read_cmd(8'h21, LAT, 1'b1, 1'b1);
    gap(3);
    read_cmd(8'h22, LAT, 1'b1, 1'b1);
    sample_at(c + 14);
    chk1("t2_no_spacing", spacing_err_o, 1'b0);
    gap(40);

    // 3: reads two cycles apart flag a spacing error; set beats clear
    c = cyc;
    read_cmd(8'h30, LAT, 1'b1, 1'b1);
    @(negedge clk);
    chk1("t3_err_before", spacing_err_o, 1'b0);
    next_cycle();
    rd_cmd_i = 1'b1;
    next_cycle();
    rd_cmd_i = 1'b0;
    @(negedge clk);
    chk1("t3_err_set", spacing_err_o, 1'b1);
    sample_at(c + 10);
    chk1("t3_err_held", spacing_err_o, 1'b1);
    gap(2);
    read_cmd(8'h31, LAT, 1'b1, 1'b1);
    rd_cmd_i    = 1'b1;
    err_clear_i = 1'b1;
    next_cycle();
    rd_cmd_i    = 1'b0;
    err_clear_i = 1'b0;
    @(negedge clk);
    chk1("t3_set_wins", spacing_err_o, 1'b1);
    pulse_clear();
    chk1("t3_cleared", spacing_err_o, 1'b0);
    gap(40);

    // 4a: five reads into a stalled four-entry FIFO; fifth word dropped
    rd_ready_i = 1'b0;
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      read_cmd(8'(64 + i), LAT, i < 4, 1'b0);
      if (i < 4) gap(3);
    end
    sample_at(c + 24);
    chk1("t4_no_overflow_yet", overflow_o, 1'b0);
    sample_at(c + 25);
    chk1("t4_overflow", overflow_o, 1'b1);
    chk1("t4_valid_held", rd_valid_o, 1'b1);
    chk1("t4_no_spacing", spacing_err_o, 1'b0);
    pulse_clear();
    chk1("t4_overflow_cleared", overflow_o, 1'b0);
    next_cycle();
    rd_ready_i = 1'b1;
    drain("t4_drain");
    gap(40);

    // 4b: push into a full FIFO with a same-cycle pop is accepted
    rd_ready_i = 1'b0;
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      read_cmd(8'(80 + i), LAT, 1'b1, 1'b0);
      if (i < 4) gap(3);
    end
    wait_cycle(c + 24);
    rd_ready_i = 1'b1;
    sample_at(c + 25);
    chk1("t4b_no_overflow", overflow_o, 1'b0);
    drain("t4b_drain");
    gap(40);

    // 5: asynchronous reset in the middle of a burst
    rd_ready_i = 1'b0;
    c = cyc;
    read_cmd(8'h60, LAT, 1'b0, 1'b0);
    rd_cmd_i = 1'b1;
    next_cycle();
    rd_cmd_i = 1'b0;
    sample_at(c + LAT + 4);
    chk1("t5_pre_valid", rd_valid_o, 1'b1);
    chk1("t5_pre_spacing", spacing_err_o, 1'b1);
    next_cycle();
    c = cyc;
    read_cmd(8'h61, LAT, 1'b0, 1'b0);
    wait_cycle(c + LAT + 1);
    rst_n = 1'b0;
    #1;
    chk1("t5_rst_valid", rd_valid_o, 1'b0);
    check("t5_rst_data", rd_data_o, '0);
    chk1("t5_rst_spacing", spacing_err_o, 1'b0);
    chk1("t5_rst_overflow", overflow_o, 1'b0);
    gap(2);
    rst_n      = 1'b1;
    rd_ready_i = 1'b1;
    gap(20);
    @(negedge clk);
    chk1("t5_no_word_after", rd_valid_o, 1'b0);
    gap(40);

    // 6: bad DQS on lane 1 in capture cycle 2; word still delivered
    c = cyc;
    dqs_fall_tab[c + LAT + 2] = 2'b10;
    read_cmd(8'h70, LAT, 1'b1, 1'b1);
    sample_at(c + LAT + 2);
    chk1("t6_dqs_before", dqs_err_o, 1'b0);
    sample_at(c + LAT + 3);
    chk1("t6_dqs_flag", dqs_err_o, DQS_EXP);
    pulse_clear();
    chk1("t6_dqs_cleared", dqs_err_o, 1'b0);
    gap(40);

    // 7: latency 0 is clamped to 1
    cfg_rd_latency_i = 6'd0;
    gap(3);
    read_cmd(8'h80, 1, 1'b1, 1'b1);
    drain("t7_drain");
    cfg_rd_latency_i = 6'(LAT);
    gap(10);

    drain("final_drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
